// File: rtl/ising_config.sv
// Shared constants for the Ising transmit path: value width, GPIO bus field layout,
// configuration register addresses and the DAC driver state encoding.
package ising_config;

    localparam int NUM_BITS = 4;

    localparam int GPIO_W          = 32;
    localparam int GPIO_WCLK_BIT   = 31;
    localparam int GPIO_ADDR_START = 16;
    localparam int GPIO_ADDR_END   = 30;
    localparam int GPIO_DATA_START = 0;
    localparam int GPIO_DATA_END   = 15;
    localparam int GPIO_ADDR_W     = GPIO_ADDR_END - GPIO_ADDR_START + 1;
    localparam int GPIO_DATA_W     = GPIO_DATA_END - GPIO_DATA_START + 1;

    localparam int CODE_W = 16;
    localparam int LANES  = 8;
    localparam int AXIS_W = CODE_W * LANES;

    localparam logic [GPIO_ADDR_W-1:0] LUT_ADDR_REG  = 15'd4;
    localparam logic [GPIO_ADDR_W-1:0] LUT_DATA_REG  = 15'd5;
    localparam logic [GPIO_ADDR_W-1:0] PULSE_LEN_REG = 15'd6;
    localparam logic [GPIO_ADDR_W-1:0] PULSE_DEL_REG = 15'd7;
    localparam logic [GPIO_ADDR_W-1:0] IDLE_CODE_REG = 15'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DELAY  = 2'd2,
        PULSE  = 2'd3
    } dac_state_t;

endpackage

// File: rtl/config_reg.sv
// Single GPIO-addressed configuration register; loads on a write strobe whose address matches.
module config_reg
    import ising_config::*;
#(
    parameter logic [GPIO_ADDR_W-1:0] ADDR  = '0,
    parameter int                     WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_stb,
    input  logic [GPIO_ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]       i_wr_data,
    output logic [WIDTH-1:0]       o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_wr_stb && (i_wr_addr == ADDR)) begin
            r_q <= i_wr_data;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dac_code_lut.sv
// Value-to-DAC-code table: GPIO pointer/data write port and a one-cycle registered read port.
// The read register only loads on i_rd_en, so it holds the looked-up code for a whole pulse.
module dac_code_lut
    import ising_config::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_stb,
    input  logic [GPIO_ADDR_W-1:0] i_wr_addr,
    input  logic [CODE_W-1:0]      i_wr_data,
    input  logic                   i_rd_en,
    input  logic [NUM_BITS-1:0]    i_rd_addr,
    output logic [CODE_W-1:0]      o_rd_data
);

    localparam int DEPTH = 2 ** NUM_BITS;

    logic [NUM_BITS-1:0] r_ptr;
    logic [CODE_W-1:0]   r_table [DEPTH];
    logic [CODE_W-1:0]   r_rd_data;
    logic                w_ptr_wr;
    logic                w_data_wr;

    assign w_ptr_wr  = i_wr_stb && (i_wr_addr == LUT_ADDR_REG);
    assign w_data_wr = i_wr_stb && (i_wr_addr == LUT_DATA_REG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_ptr_wr) begin
            r_ptr <= i_wr_data[NUM_BITS-1:0];
        end
    end

    // Table contents must clear on reset, so this is a register file rather than a RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_data_wr) begin
            r_table[r_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_table[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dac_driver.sv
// Turns one spin/amplitude value into a timed pulse of 128-bit DAC words; idle_code is
// driven on all lanes outside the pulse. Stream outputs are decoded from registered state only.
module dac_driver
    import ising_config::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [GPIO_W-1:0]   gpio_in,
    input  logic [NUM_BITS-1:0] val_in,
    input  logic                val_in_valid,
    output logic                val_in_ready,
    output logic [AXIS_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                busy,
    output logic                pulse_done
);

    logic [2:0]             r_wclk_sync;
    logic                   w_wr_stb;
    logic [GPIO_ADDR_W-1:0] w_gpio_addr;
    logic [GPIO_DATA_W-1:0] w_gpio_data;

    logic [7:0]             w_cfg_len;
    logic [7:0]             w_cfg_del;
    logic [CODE_W-1:0]      w_idle_code;
    logic [CODE_W-1:0]      w_code_q;

    dac_state_t             r_state;
    dac_state_t             w_state_next;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_next;
    logic [7:0]             r_len;
    logic [NUM_BITS-1:0]    r_val;
    logic                   r_tvalid;
    logic                   w_hs;
    logic                   w_accept;
    logic                   w_lut_rd;
    logic                   w_done;

    // Bits [1:0] synchronise w_clk, bit [2] is the previous synchronised value for edge detect.
    // Address/data are assumed held stable by the GPIO master across the w_clk pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wclk_sync <= '0;
        end else begin
            r_wclk_sync <= {r_wclk_sync[1:0], gpio_in[GPIO_WCLK_BIT]};
        end
    end

    assign w_wr_stb    = r_wclk_sync[1] & ~r_wclk_sync[2];
    assign w_gpio_addr = gpio_in[GPIO_ADDR_END:GPIO_ADDR_START];
    assign w_gpio_data = gpio_in[GPIO_DATA_END:GPIO_DATA_START];

    config_reg #(.ADDR(PULSE_LEN_REG), .WIDTH(8)) u_len_reg (
        .clk       (clk),
        .rst       (rst),
        .i_wr_stb  (w_wr_stb),
        .i_wr_addr (w_gpio_addr),
        .i_wr_data (w_gpio_data[7:0]),
        .o_q       (w_cfg_len)
    );

    config_reg #(.ADDR(PULSE_DEL_REG), .WIDTH(8)) u_del_reg (
        .clk       (clk),
        .rst       (rst),
        .i_wr_stb  (w_wr_stb),
        .i_wr_addr (w_gpio_addr),
        .i_wr_data (w_gpio_data[7:0]),
        .o_q       (w_cfg_del)
    );

    config_reg #(.ADDR(IDLE_CODE_REG), .WIDTH(CODE_W)) u_idle_reg (
        .clk       (clk),
        .rst       (rst),
        .i_wr_stb  (w_wr_stb),
        .i_wr_addr (w_gpio_addr),
        .i_wr_data (w_gpio_data),
        .o_q       (w_idle_code)
    );

    dac_code_lut u_lut (
        .clk       (clk),
        .rst       (rst),
        .i_wr_stb  (w_wr_stb),
        .i_wr_addr (w_gpio_addr),
        .i_wr_data (w_gpio_data),
        .i_rd_en   (w_lut_rd),
        .i_rd_addr (r_val),
        .o_rd_data (w_code_q)
    );

    assign w_hs         = r_tvalid & m_axis_tready;
    assign val_in_ready = (r_state == IDLE) & r_tvalid;
    assign w_accept     = val_in_valid & val_in_ready;

    // r_cnt holds the remaining delay words, then the remaining pulse words.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_lut_rd     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = LOOKUP;
                    w_cnt_next   = w_cfg_del;
                end
            end
            LOOKUP: begin
                w_lut_rd = 1'b1;
                if (r_cnt != 8'd0) begin
                    w_state_next = DELAY;
                end else begin
                    w_state_next = PULSE;
                    w_cnt_next   = r_len;
                end
            end
            DELAY: begin
                if (w_hs) begin
                    if (r_cnt == 8'd1) begin
                        w_state_next = PULSE;
                        w_cnt_next   = r_len;
                    end else begin
                        w_cnt_next = r_cnt - 8'd1;
                    end
                end
            end
            PULSE: begin
                if (w_hs) begin
                    if (r_cnt == 8'd1) begin
                        w_state_next = IDLE;
                        w_cnt_next   = 8'd0;
                        w_done       = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            r_val    <= '0;
            r_tvalid <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_tvalid <= 1'b1;
            if (w_accept) begin
                r_val <= val_in;
                r_len <= (w_cfg_len == 8'd0) ? 8'd1 : w_cfg_len;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign m_axis_tdata[gi*CODE_W +: CODE_W] = (r_state == PULSE) ? w_code_q : w_idle_code;
        end
    endgenerate

    assign m_axis_tvalid = r_tvalid;
    assign busy          = (r_state != IDLE);
    assign pulse_done    = w_done;

endmodule

// File: tb/tb_dac_driver.sv
// Bench for dac_driver: a word-queue model of the expected stream checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dac_driver;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  gpio_in = '0;
    logic [3:0]   val_in = '0;
    logic         val_in_valid = 1'b0;
    logic         m_axis_tready = 1'b1;
    logic         val_in_ready;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         busy;
    logic         pulse_done;

    always #5 clk = ~clk;

    dac_driver dut (
        .clk           (clk),
        .rst           (rst),
        .gpio_in       (gpio_in),
        .val_in        (val_in),
        .val_in_valid  (val_in_valid),
        .val_in_ready  (val_in_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .pulse_done    (pulse_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: words still owed to the DAC after an accept ({is_pulse, code}), plus the
    // single lookup cycle that precedes them.
    logic        m_valid = 1'b0;
    logic        m_lookup = 1'b0;
    logic [16:0] q[$];
    logic [15:0] m_idle = '0;
    logic [15:0] m_lut [16];
    logic [7:0]  m_len = '0;
    logic [7:0]  m_del = '0;
    logic [3:0]  m_ptr = '0;
    bit          chk_on = 1'b1;

    int cnt_pulse = 0, cnt_idle_busy = 0, cnt_done = 0, cnt_a = 0, cnt_b = 0;
    int b_pulse, b_idle_busy, b_done, b_a, b_b;
    logic [15:0] code_a = '0, code_b = '0;
    int acc_cyc = 0, lat = -1;
    bit seen_pulse = 1'b0, last_acc = 1'b0;

    function automatic logic [127:0] lanes(input logic [15:0] c);
        return {8{c}};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic compare();
        logic [127:0] e_data;
        logic e_valid, e_ready, e_busy, e_done;
        e_data = '0; e_valid = 1'b0; e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (rst) begin
            e_valid = m_valid;
            e_data  = lanes(m_idle);
            if (m_valid) begin
                if (m_lookup) begin
                    e_busy = 1'b1;
                end else if (q.size() != 0) begin
                    e_busy = 1'b1;
                    if (q[0][16]) e_data = lanes(q[0][15:0]);
                    e_done = m_axis_tready && (q.size() == 1);
                end else begin
                    e_ready = 1'b1;
                end
            end
        end
        n_checks++;
        if (m_axis_tdata !== e_data || m_axis_tvalid !== e_valid || val_in_ready !== e_ready ||
            busy !== e_busy || pulse_done !== e_done) begin
            n_errors++;
            $display("FAIL stream cyc=%0d got data=%h v=%b rdy=%b busy=%b done=%b expected data=%h v=%b rdy=%b busy=%b done=%b",
                     cyc, m_axis_tdata, m_axis_tvalid, val_in_ready, busy, pulse_done,
                     e_data, e_valid, e_ready, e_busy, e_done);
        end
    endtask

    task automatic stats();
        last_acc = val_in_valid && val_in_ready;
        if (last_acc) begin
            acc_cyc = cyc;
            seen_pulse = 1'b0;
        end
        if (rst && busy && !seen_pulse && m_axis_tdata != lanes(m_idle)) begin
            seen_pulse = 1'b1;
            lat = cyc - acc_cyc;
        end
        if (rst && m_axis_tvalid && m_axis_tready && busy) begin
            if (m_axis_tdata == lanes(m_idle)) cnt_idle_busy++;
            else cnt_pulse++;
            if (m_axis_tdata == lanes(code_a)) cnt_a++;
            if (m_axis_tdata == lanes(code_b)) cnt_b++;
        end
        if (pulse_done) cnt_done++;
    endtask

    task automatic model_advance();
        bit hs, was_idle;
        int n;
        if (rst) begin
            hs       = m_valid && m_axis_tready;
            was_idle = m_valid && !m_lookup && (q.size() == 0);
            if (m_lookup) m_lookup = 1'b0;
            else if (q.size() != 0 && hs) void'(q.pop_front());
            if (was_idle && val_in_valid) begin
                m_lookup = 1'b1;
                for (int i = 0; i < int'(m_del); i++) q.push_back({1'b0, 16'h0000});
                n = (m_len == 8'd0) ? 1 : int'(m_len);
                for (int i = 0; i < n; i++) q.push_back({1'b1, m_lut[val_in]});
            end
            m_valid = 1'b1;
        end
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        if (chk_on) compare();
        stats();
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic gpio_write(input logic [14:0] a, input logic [15:0] d);
        if (a == 15'd8) chk_on = 1'b0;
        gpio_in = {1'b0, a, d};
        step(); step();
        gpio_in[31] = 1'b1;
        repeat (4) step();
        gpio_in[31] = 1'b0;
        repeat (3) step();
        case (a)
            15'd4: m_ptr = d[3:0];
            15'd5: m_lut[m_ptr] = d;
            15'd6: m_len = d[7:0];
            15'd7: m_del = d[7:0];
            15'd8: m_idle = d;
            default: ;
        endcase
        chk_on = 1'b1;
    endtask

    task automatic send(input logic [3:0] v);
        int n;
        val_in = v;
        val_in_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 200);
        if (!last_acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: value %0d not accepted within 200 cycles", v);
        end
        val_in_valid = 1'b0;
    endtask

    task automatic snap();
        b_pulse = cnt_pulse; b_idle_busy = cnt_idle_busy; b_done = cnt_done; b_a = cnt_a; b_b = cnt_b;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_lut[i] = '0;
        repeat (3) step();
        rst = 1'b1;

        // 1: reset then idle words
        gpio_write(15'd8, 16'h0010);
        repeat (5) step();
        check("t1_idle_word", m_axis_tdata, 128'h00100010001000100010001000100010);
        check("t1_tvalid", {127'd0, m_axis_tvalid}, 128'd1);
        check("t1_busy", {127'd0, busy}, 128'd0);

        // 2: single pulse, len=3 del=0
        gpio_write(15'd4, 16'd1);
        gpio_write(15'd5, 16'h7FFF);
        gpio_write(15'd6, 16'd3);
        gpio_write(15'd7, 16'd0);
        code_a = 16'h7FFF;
        snap();
        send(4'd1);
        step();
        check("t2_first_word", m_axis_tdata, 128'h7FFF7FFF7FFF7FFF7FFF7FFF7FFF7FFF);
        repeat (8) step();
        check("t2_latency", lat, 2);
        check("t2_words", cnt_pulse - b_pulse, 3);
        check("t2_code_words", cnt_a - b_a, 3);
        check("t2_done", cnt_done - b_done, 1);

        // 3: del=4, len=2, five stalled cycles inside DELAY
        gpio_write(15'd4, 16'd2);
        gpio_write(15'd5, 16'h4000);
        gpio_write(15'd6, 16'd2);
        gpio_write(15'd7, 16'd4);
        snap();
        send(4'd2);
        step(); step();
        m_axis_tready = 1'b0;
        repeat (3) step();
        check("t3_stalled_word", m_axis_tdata, 128'h00100010001000100010001000100010);
        repeat (2) step();
        m_axis_tready = 1'b1;
        repeat (15) step();
        check("t3_latency", lat, 11);
        check("t3_idle_words", cnt_idle_busy - b_idle_busy, 5);
        check("t3_pulse_words", cnt_pulse - b_pulse, 2);
        check("t3_done", cnt_done - b_done, 1);

        // 4: len=0 gives exactly one word
        gpio_write(15'd4, 16'd0);
        gpio_write(15'd5, 16'h8000);
        gpio_write(15'd6, 16'd0);
        gpio_write(15'd7, 16'd0);
        snap();
        send(4'd0);
        step();
        check("t4_word", m_axis_tdata, 128'h80008000800080008000800080008000);
        check("t4_done_now", {127'd0, pulse_done}, 128'd1);
        step();
        check("t4_ready_after", {127'd0, val_in_ready}, 128'd1);
        repeat (5) step();
        check("t4_words", cnt_pulse - b_pulse, 1);
        check("t4_done", cnt_done - b_done, 1);

        // 5: config rewritten during a stalled len=3 pulse; next request held off while busy
        gpio_write(15'd4, 16'd1);
        gpio_write(15'd5, 16'h1234);
        gpio_write(15'd6, 16'd3);
        code_a = 16'h1234;
        code_b = 16'hBEEF;
        snap();
        send(4'd1);
        m_axis_tready = 1'b0;
        gpio_write(15'd6, 16'd10);
        gpio_write(15'd4, 16'd1);
        gpio_write(15'd5, 16'hBEEF);
        m_axis_tready = 1'b1;
        send(4'd1);
        repeat (15) step();
        check("t5_old_words", cnt_a - b_a, 3);
        check("t5_new_words", cnt_b - b_b, 10);
        check("t5_done", cnt_done - b_done, 2);
        check("t5_latency", lat, 2);

        // 6: reset asserted mid-pulse
        send(4'd1);
        repeat (3) step();
        check("t6_in_pulse", m_axis_tdata, 128'hBEEFBEEFBEEFBEEFBEEFBEEFBEEFBEEF);
        #1 rst = 1'b0;
        #1;
        check("t6_rst_tdata", m_axis_tdata, 128'd0);
        check("t6_rst_ctl", {123'd0, m_axis_tvalid, val_in_ready, busy, pulse_done}, 128'd0);
        m_valid = 1'b0; m_lookup = 1'b0; q.delete();
        m_idle = '0; m_len = '0; m_del = '0; m_ptr = '0;
        for (int i = 0; i < 16; i++) m_lut[i] = '0;
        repeat (3) step();
        rst = 1'b1;
        repeat (4) step();
        check("t6_ready_after", {127'd0, val_in_ready}, 128'd1);
        check("t6_idle_after", m_axis_tdata, 128'd0);
        check("t6_tvalid_after", {127'd0, m_axis_tvalid}, 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
